cache_tag_ctrl: RTL and testbench

//  Lookup/refill sequencer for the direct-mapped cache tag store (256 x 20b sync-read RAM).

---
 rtl/cache_tag_ctrl_pkg.sv | 20 ++
 rtl/cache_tag_ctrl_valid_array.sv | 36 +++
 rtl/cache_tag_ctrl.sv | 141 ++++++++++++++
 tb/tb_cache_tag_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_tag_ctrl_pkg.sv
// Shared constants and state encoding for the cache tag lookup/refill sequencer.
package cache_tag_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_INDEX_AW   = 8;
  localparam int DEF_OFFSET_AW  = 4;
  localparam int DEF_TAG_WIDTH  = DEF_ADDR_WIDTH - DEF_INDEX_AW - DEF_OFFSET_AW;
  localparam int DEF_NUM_LINES  = 2 ** DEF_INDEX_AW;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_WAIT = 3'd3,
    ST_FILL      = 3'd4,
    ST_RESP      = 3'd5,
    ST_FLUSH     = 3'd6
  } state_t;

endpackage

// File: rtl/cache_tag_ctrl_valid_array.sv
// Per-line valid bits: set one line by index, clear all lines at once, read by index.
module cache_valid_array #(
  parameter int INDEX_AW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [INDEX_AW-1:0] set_idx,
  input  logic                clr_all,
  input  logic [INDEX_AW-1:0] rd_idx,
  output logic                rd_valid
);

  localparam int NUM_LINES = 2 ** INDEX_AW;

  logic [NUM_LINES-1:0] valid_reg;

  // Flash clear wins over a same-cycle set so a flush never leaves a stale line behind.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_line
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg[gi] <= 1'b0;
        end else if (clr_all) begin
          valid_reg[gi] <= 1'b0;
        end else if (set_en && (set_idx == INDEX_AW'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign rd_valid = valid_reg[rd_idx];

endmodule

// File: rtl/cache_tag_ctrl.sv
// Direct-mapped cache tag sequencer: lookup, miss refill handshake, tag fill and invalidate-all.
module cache_tag_ctrl
  import cache_tag_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int INDEX_AW   = DEF_INDEX_AW,
  parameter int OFFSET_AW  = DEF_OFFSET_AW
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        req_valid_i,
  output logic                                        req_ready_o,
  input  logic [ADDR_WIDTH-1:0]                       req_addr_i,
  output logic                                        resp_valid_o,
  output logic                                        resp_hit_o,
  input  logic                                        flush_i,
  output logic                                        flush_done_o,
  output logic                                        refill_req_valid_o,
  input  logic                                        refill_req_ready_i,
  output logic [ADDR_WIDTH-1:0]                       refill_addr_o,
  input  logic                                        refill_done_i,
  output logic [INDEX_AW-1:0]                         tag_index_o,
  output logic                                        tag_wr_en_o,
  output logic [ADDR_WIDTH-INDEX_AW-OFFSET_AW-1:0]    tag_wr_tag_o,
  input  logic [ADDR_WIDTH-INDEX_AW-OFFSET_AW-1:0]    tag_rd_tag_i
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_AW - OFFSET_AW;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  flush_pend_reg;
  logic                  hit_reg;

  logic [INDEX_AW-1:0]   lat_index;
  logic [TAG_WIDTH-1:0]  lat_tag;
  logic                  line_valid;
  logic                  lookup_hit;
  logic                  flush_req;
  logic                  accept;

  assign lat_index  = addr_reg[OFFSET_AW +: INDEX_AW];
  assign lat_tag    = addr_reg[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign flush_req  = flush_i | flush_pend_reg;
  assign lookup_hit = line_valid & (tag_rd_tag_i == lat_tag);

  cache_valid_array #(
    .INDEX_AW (INDEX_AW)
  ) u_valid (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (state_reg == ST_FILL),
    .set_idx  (lat_index),
    .clr_all  (state_reg == ST_FLUSH),
    .rd_idx   (lat_index),
    .rd_valid (line_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      flush_pend_reg <= 1'b0;
      hit_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg <= req_addr_i;
      end
      // A flush seen mid-operation is parked until the op drains back to idle.
      if (state_reg == ST_FLUSH) begin
        flush_pend_reg <= 1'b0;
      end else if (flush_i && (state_reg != ST_IDLE)) begin
        flush_pend_reg <= 1'b1;
      end
      if (state_reg == ST_LOOKUP) begin
        hit_reg <= lookup_hit;
      end
    end
  end

  always_comb begin
    state_next         = state_reg;
    accept             = 1'b0;
    req_ready_o        = 1'b0;
    resp_valid_o       = 1'b0;
    resp_hit_o         = 1'b0;
    flush_done_o       = 1'b0;
    refill_req_valid_o = 1'b0;
    tag_wr_en_o        = 1'b0;
    tag_index_o        = lat_index;

    case (state_reg)
      ST_IDLE: begin
        // Index goes straight from the request so the RAM read starts on the accepting edge.
        tag_index_o = req_addr_i[OFFSET_AW +: INDEX_AW];
        req_ready_o = !flush_req;
        if (flush_req) begin
          state_next = ST_FLUSH;
        end else if (req_valid_i) begin
          accept     = 1'b1;
          state_next = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        state_next = lookup_hit ? ST_RESP : ST_MISS_REQ;
      end
      ST_MISS_REQ: begin
        refill_req_valid_o = 1'b1;
        if (refill_req_ready_i) begin
          state_next = ST_MISS_WAIT;
        end
      end
      ST_MISS_WAIT: begin
        if (refill_done_i) begin
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        tag_wr_en_o = 1'b1;
        state_next  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_hit_o   = hit_reg;
        state_next   = ST_IDLE;
      end
      ST_FLUSH: begin
        flush_done_o = 1'b1;
        state_next   = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign refill_addr_o = {addr_reg[ADDR_WIDTH-1:OFFSET_AW], {OFFSET_AW{1'b0}}};
  assign tag_wr_tag_o  = lat_tag;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Bench for cache_tag_ctrl: behavioural tag RAM, scoreboard queues, vector table plus corner sequences.
module tb_cache_tag_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        resp_valid_o;
  logic        resp_hit_o;
  logic        flush_i;
  logic        flush_done_o;
  logic        refill_req_valid_o;
  logic        refill_req_ready_i;
  logic [31:0] refill_addr_o;
  logic        refill_done_i;
  logic [7:0]  tag_index_o;
  logic        tag_wr_en_o;
  logic [19:0] tag_wr_tag_o;
  logic [19:0] tag_rd_tag_i;

  cache_tag_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_addr_i         (req_addr_i),
    .resp_valid_o       (resp_valid_o),
    .resp_hit_o         (resp_hit_o),
    .flush_i            (flush_i),
    .flush_done_o       (flush_done_o),
    .refill_req_valid_o (refill_req_valid_o),
    .refill_req_ready_i (refill_req_ready_i),
    .refill_addr_o      (refill_addr_o),
    .refill_done_i      (refill_done_i),
    .tag_index_o        (tag_index_o),
    .tag_wr_en_o        (tag_wr_en_o),
    .tag_wr_tag_o       (tag_wr_tag_o),
    .tag_rd_tag_i       (tag_rd_tag_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sync-read tag RAM living in the cache top.
  logic [19:0] tag_mem [256];
  always @(posedge clk) begin
    if (tag_wr_en_o) tag_mem[tag_index_o] <= tag_wr_tag_o;
    tag_rd_tag_i <= tag_mem[tag_index_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard queues: pushed at stimulus time, popped when the DUT produces the event.
  bit          resp_q   [$];
  logic [31:0] refill_q [$];
  logic [27:0] twr_q    [$];
  int flush_req_cnt  = 0;
  int flush_done_cnt = 0;
  int resp_cyc       = 0;
  int flush_done_cyc = 0;
  bit prev_rv        = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rv <= 1'b0;
    end else begin
      if (refill_req_valid_o && !prev_rv) begin
        if (refill_q.size() == 0) chk("refill_unexpected", 32'(1), 32'(0));
        else chk("refill_addr", refill_addr_o, refill_q.pop_front());
      end
      prev_rv <= refill_req_valid_o;
      if (tag_wr_en_o) begin
        if (twr_q.size() == 0) chk("tag_wr_unexpected", 32'(1), 32'(0));
        else chk("tag_wr_idx_tag", 32'({tag_index_o, tag_wr_tag_o}), 32'(twr_q.pop_front()));
      end
      if (resp_valid_o) begin
        if (resp_q.size() == 0) chk("resp_unexpected", 32'(1), 32'(0));
        else chk("resp_hit", 32'(resp_hit_o), 32'(resp_q.pop_front()));
        resp_cyc <= cyc;
      end
      if (flush_done_o) begin
        chk("flush_done_expected", 32'(flush_done_cnt < flush_req_cnt), 32'(1));
        flush_done_cnt <= flush_done_cnt + 1;
        flush_done_cyc <= cyc;
      end
    end
  end

  task automatic clear_sb();
    resp_q.delete();
    refill_q.delete();
    twr_q.delete();
  endtask

  // One complete lookup, acting as the memory side when a refill is expected.
  task automatic lookup(input logic [31:0] addr, input bit exp_hit, input int rdy_dly,
                        input int done_dly, input bit early_done, input bit flush_in_wait,
                        input bit flush_with_req);
    int n;
    int hs_cyc;
    int rf_cyc;
    int done_cyc;
    logic [31:0] held_addr;
    $display("lookup addr=%08h exp_hit=%0d rdy_dly=%0d done_dly=%0d", addr, exp_hit, rdy_dly, done_dly);
    resp_q.push_back(exp_hit);
    if (!exp_hit) begin
      refill_q.push_back({addr[31:4], 4'h0});
      twr_q.push_back({addr[11:4], addr[31:12]});
    end
    req_addr_i  = addr;
    req_valid_i = 1'b1;
    if (flush_with_req) begin
      flush_i = 1'b1;
      flush_req_cnt++;
      @(negedge clk);
      chk("ready_low_with_flush", 32'(req_ready_o), 32'(0));
      @(posedge clk); #1;
      flush_i = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      chk("accept_timeout", 32'(1), 32'(0));
      req_valid_i = 1'b0;
      clear_sb();
      return;
    end
    hs_cyc = cyc;
    if (flush_with_req) chk("accept_after_flush_done", 32'(hs_cyc - flush_done_cyc), 32'(1));
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    done_cyc = 0;

    if (!exp_hit) begin
      n = 0;
      @(negedge clk);
      while (!refill_req_valid_o && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!refill_req_valid_o) begin
        chk("refill_timeout", 32'(1), 32'(0));
        clear_sb();
        return;
      end
      rf_cyc = cyc;
      chk("refill_latency", 32'(rf_cyc - hs_cyc), 32'(2));
      held_addr = refill_addr_o;
      for (int i = 0; i < rdy_dly; i++) begin
        if (early_done && i == 0) refill_done_i = 1'b1;
        @(posedge clk); #1;
        refill_done_i = 1'b0;
        @(negedge clk);
        chk("refill_hold_valid", 32'(refill_req_valid_o), 32'(1));
        chk("refill_hold_addr", refill_addr_o, held_addr);
      end
      refill_req_ready_i = 1'b1;
      @(posedge clk); #1;
      refill_req_ready_i = 1'b0;
      if (flush_in_wait) begin
        flush_i = 1'b1;
        flush_req_cnt++;
        @(posedge clk); #1;
        flush_i = 1'b0;
      end
      @(negedge clk);
      chk("refill_valid_drop", 32'(refill_req_valid_o), 32'(0));
      repeat (done_dly) @(posedge clk);
      @(negedge clk);
      refill_done_i = 1'b1;
      done_cyc = cyc;
      @(posedge clk); #1;
      refill_done_i = 1'b0;
    end

    n = 0;
    while (resp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (resp_q.size() != 0) begin
      chk("resp_timeout", 32'(1), 32'(0));
      clear_sb();
      return;
    end
    if (exp_hit) chk("hit_latency", 32'(resp_cyc - hs_cyc), 32'(2));
    else         chk("miss_latency", 32'(resp_cyc - done_cyc), 32'(2));
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    int          rdy_dly;
    int          done_dly;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{32'h0000_1234, 1'b0, 0, 1};  // cold miss, idx 0x23 tag 0x00001
    vecs[1]  = '{32'h0000_1238, 1'b1, 0, 0};
    vecs[2]  = '{32'h0001_1230, 1'b0, 1, 2};  // conflict, tag 0x00011
    vecs[3]  = '{32'h0000_1230, 1'b0, 0, 0};
    vecs[4]  = '{32'h0000_1230, 1'b1, 0, 0};
    vecs[5]  = '{32'h0000_000C, 1'b0, 2, 1};  // idx 0x00, tag 0 equals RAM init
    vecs[6]  = '{32'hFFFF_FFF0, 1'b0, 0, 3};  // idx 0xFF
    vecs[7]  = '{32'h0000_0004, 1'b1, 0, 0};
    vecs[8]  = '{32'hFFFF_FFFF, 1'b1, 0, 0};
    vecs[9]  = '{32'h0000_0FF0, 1'b0, 1, 1};
    vecs[10] = '{32'hFFFF_FFF8, 1'b0, 0, 0};
    vecs[11] = '{32'h0000_0FF4, 1'b0, 0, 0};

    for (int i = 0; i < 256; i++) tag_mem[i] = 20'h0;
    rst_n = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i = 32'h0;
    flush_i = 1'b0;
    refill_req_ready_i = 1'b0;
    refill_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready_o), 32'(1));
    chk("rst_resp_valid", 32'(resp_valid_o), 32'(0));
    chk("rst_resp_hit", 32'(resp_hit_o), 32'(0));
    chk("rst_flush_done", 32'(flush_done_o), 32'(0));
    chk("rst_refill_valid", 32'(refill_req_valid_o), 32'(0));
    chk("rst_refill_addr", refill_addr_o, 32'h0);
    chk("rst_tag_wr_en", 32'(tag_wr_en_o), 32'(0));
    chk("rst_tag_wr_tag", 32'(tag_wr_tag_o), 32'(0));
    chk("rst_tag_index", 32'(tag_index_o), 32'(0));
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      lookup(vecs[i].addr, vecs[i].exp_hit, vecs[i].rdy_dly, vecs[i].done_dly, 1'b0, 1'b0, 1'b0);

    // Backpressure with an early done pulse while the request is still unaccepted.
    lookup(32'h0002_3230, 1'b0, 5, 3, 1'b1, 1'b0, 1'b0);
    lookup(32'h0002_323C, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    // Flush raised during MISS_WAIT: the miss finishes first, then the flush runs.
    lookup(32'h0000_5670, 1'b0, 0, 4, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (flush_done_cnt != flush_req_cnt && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("flush_mid_miss_done", 32'(flush_done_cnt), 32'(flush_req_cnt));
    chk("flush_after_resp", 32'(flush_done_cyc - resp_cyc), 32'(2));
    lookup(32'h0002_3230, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Flush and request in the same idle cycle.
    lookup(32'h0002_3234, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1);
    lookup(32'h0002_3234, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset while a refill request is outstanding.
    $display("reset during refill addr=%08h", 32'h0000_ABC0);
    refill_q.push_back(32'h0000_ABC0);
    req_addr_i = 32'h0000_ABC0;
    req_valid_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!refill_req_valid_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("midop_refill_seen", 32'(refill_req_valid_o), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("midop_rst_refill_valid", 32'(refill_req_valid_o), 32'(0));
    chk("midop_rst_ready", 32'(req_ready_o), 32'(1));
    chk("midop_rst_refill_addr", refill_addr_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_sb();
    lookup(32'h0002_3230, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    lookup(32'h0002_323C, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_resp_empty", 32'(resp_q.size()), 32'(0));
    chk("sb_refill_empty", 32'(refill_q.size()), 32'(0));
    chk("sb_twr_empty", 32'(twr_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
